// File: rtl/stream_video_filter_pkg.sv
// Shared widths, sideband type and channel helpers for the box-filter video core.
package stream_video_filter_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned N_CH  = PIX_W / CH_W;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [CH_W-1:0]  chan_t;

  typedef struct packed {
    logic user;
    logic last;
  } side_t;

  function automatic int unsigned sum_width(input int unsigned dim);
    return $clog2(((1 << CH_W) - 1) * dim * dim + 1);
  endfunction

  function automatic chan_t get_ch(input pixel_t pix, input int unsigned idx);
    return pix[idx*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/svf_line_buffer.sv
// One video line of pixels; combinational read of the old word, write on enable.
module svf_line_buffer
  import stream_video_filter_pkg::*;
#(
  parameter int unsigned MAX_LINE = 2048
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [$clog2(MAX_LINE)-1:0] addr,
  input  logic [PIX_W-1:0]            wr_data,
  output logic [PIX_W-1:0]            rd_data
);

  pixel_t mem [MAX_LINE];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/stream_video_filter_core.sv
// Causal FILTER_DIM x FILTER_DIM box filter on an AXI4-Stream RGB video stream.
module stream_video_filter_core
  import stream_video_filter_pkg::*;
#(
  parameter int unsigned FILTER_DIM = 3,
  parameter int unsigned MAX_LINE   = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] s_axis_video_tdata,
  input  logic             s_axis_video_tvalid,
  output logic             s_axis_video_tready,
  input  logic             s_axis_video_tuser,
  input  logic             s_axis_video_tlast,
  output logic [PIX_W-1:0] m_axis_video_tdata,
  output logic             m_axis_video_tvalid,
  input  logic             m_axis_video_tready,
  output logic             m_axis_video_tuser,
  output logic             m_axis_video_tlast
);

  localparam int unsigned AW    = $clog2(MAX_LINE);
  localparam int unsigned RW    = $clog2(FILTER_DIM);
  localparam int unsigned NLB   = FILTER_DIM - 1;
  localparam int unsigned NTAP  = FILTER_DIM * FILTER_DIM;
  localparam int unsigned SUM_W = sum_width(FILTER_DIM);

  logic          en;
  logic          accept;
  logic [AW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          over, cur_over;

  pixel_t lb_rd [NLB];
  pixel_t lb_wr [NLB];
  pixel_t col_taps [FILTER_DIM];

  logic          s1_valid;
  pixel_t        s1_taps [FILTER_DIM];
  logic [AW-1:0] s1_col;
  logic          s1_over;
  side_t         s1_side;
  pixel_t        hist [NLB][FILTER_DIM];

  logic [SUM_W-1:0] acc;
  pixel_t           result;

  assign en                  = !m_axis_video_tvalid || m_axis_video_tready;
  assign s_axis_video_tready = reset && en;
  assign accept              = s_axis_video_tvalid && s_axis_video_tready;

  // A tuser beat is itself at row 0 / col 0, so the position applies combinationally.
  assign cur_col  = s_axis_video_tuser ? '0 : col;
  assign cur_row  = s_axis_video_tuser ? '0 : row;
  assign cur_over = s_axis_video_tuser ? 1'b0 : over;

  always_ff @(posedge clk) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      over <= 1'b0;
    end else if (accept) begin
      col  <= s_axis_video_tlast ? '0 :
              (cur_col == AW'(MAX_LINE - 1)) ? cur_col : cur_col + 1'b1;
      row  <= !s_axis_video_tlast ? cur_row :
              (cur_row == RW'(FILTER_DIM - 1)) ? cur_row : cur_row + 1'b1;
      over <= !s_axis_video_tlast && (cur_over || cur_col == AW'(MAX_LINE - 1));
    end
  end

  for (genvar i = 0; i < NLB; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = s_axis_video_tdata;
    end else begin : g_chain
      assign lb_wr[i] = lb_rd[i-1];
    end

    svf_line_buffer #(.MAX_LINE(MAX_LINE)) u_lb (
      .clk     (clk),
      .en      (accept && !cur_over),
      .addr    (cur_col),
      .wr_data (lb_wr[i]),
      .rd_data (lb_rd[i])
    );
  end

  always_comb begin
    col_taps[0] = s_axis_video_tdata;
    for (int unsigned k = 1; k < FILTER_DIM; k++) begin
      col_taps[k] = (32'(cur_row) >= k && !cur_over) ? lb_rd[k-1] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) s1_valid <= 1'b0;
    else if (en) s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (en && accept) begin
      s1_taps <= col_taps;
      s1_col  <= cur_col;
      s1_over <= cur_over;
      s1_side <= '{user: s_axis_video_tuser, last: s_axis_video_tlast};
    end
  end

  // hist[j] holds the column j+1 to the left of the beat in stage 1.
  always_ff @(posedge clk) begin
    if (en && s1_valid) begin
      hist[0] <= s1_taps;
      for (int unsigned j = 1; j < NLB; j++) hist[j] <= hist[j-1];
    end
  end

  always_comb begin
    result = '0;
    acc    = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      acc = '0;
      for (int unsigned k = 0; k < FILTER_DIM; k++) begin
        acc = acc + SUM_W'(get_ch(s1_taps[k], ch));
      end
      for (int unsigned j = 0; j < NLB; j++) begin
        if (32'(s1_col) > j) begin
          for (int unsigned k = 0; k < FILTER_DIM; k++) begin
            if (k == 0 || !s1_over) acc = acc + SUM_W'(get_ch(hist[j][k], ch));
          end
        end
      end
      result[ch*CH_W +: CH_W] = CH_W'(acc / SUM_W'(NTAP));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
    end else if (en) begin
      m_axis_video_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_video_tdata <= result;
        m_axis_video_tuser <= s1_side.user;
        m_axis_video_tlast <= s1_side.last;
      end
    end
  end

endmodule

// File: tb/tb_stream_video_filter_core.sv
// Self-checking bench for stream_video_filter_core against a frame-image reference model.
module tb_stream_video_filter_core;

  localparam int W = 20;
  localparam int H = 10;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] s_axis_video_tdata = '0;
  logic        s_axis_video_tvalid = 1'b0;
  logic        s_axis_video_tready;
  logic        s_axis_video_tuser = 1'b0;
  logic        s_axis_video_tlast = 1'b0;
  logic [23:0] m_axis_video_tdata;
  logic        m_axis_video_tvalid;
  logic        m_axis_video_tready = 1'b1;
  logic        m_axis_video_tuser;
  logic        m_axis_video_tlast;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int stall_seen = 0;
  int stall_bad = 0;
  bit prev_stall = 0;
  beat_t held;

  beat_t out_q[$];
  int    out_cyc[$];
  int    in_cyc[$];
  beat_t rand_frame[$];
  beat_t ref_out[$];

  stream_video_filter_core #(.FILTER_DIM(3), .MAX_LINE(2048)) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_axis_video_tdata  (s_axis_video_tdata),
    .s_axis_video_tvalid (s_axis_video_tvalid),
    .s_axis_video_tready (s_axis_video_tready),
    .s_axis_video_tuser  (s_axis_video_tuser),
    .s_axis_video_tlast  (s_axis_video_tlast),
    .m_axis_video_tdata  (m_axis_video_tdata),
    .m_axis_video_tvalid (m_axis_video_tvalid),
    .m_axis_video_tready (m_axis_video_tready),
    .m_axis_video_tuser  (m_axis_video_tuser),
    .m_axis_video_tlast  (m_axis_video_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 m_axis_video_tready = ($urandom_range(99) < rdy_pct);
  end

  // Output monitor: collects accepted beats and tracks hold behaviour during stalls.
  always @(negedge clk) begin
    if (reset && m_axis_video_tvalid) begin
      if (prev_stall) begin
        stall_seen++;
        if (m_axis_video_tdata !== held.d || m_axis_video_tuser !== held.u ||
            m_axis_video_tlast !== held.l) stall_bad++;
      end
      if (m_axis_video_tready) begin
        out_q.push_back('{m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast});
        out_cyc.push_back(cyc);
      end
      prev_stall = !m_axis_video_tready;
      held = '{m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast};
    end else begin
      if (reset && prev_stall) stall_bad++;
      prev_stall = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Reference: keep the frame as an image and average the window from real coordinates.
  task automatic model(input beat_t in_b[$], output beat_t exp_b[$]);
    int img [64][32];
    int r, c, sum;
    beat_t e;
    exp_b = {};
    r = 0;
    c = 0;
    foreach (img[i, j]) img[i][j] = 0;
    foreach (in_b[n]) begin
      if (in_b[n].u) begin
        r = 0;
        c = 0;
        foreach (img[i, j]) img[i][j] = 0;
      end
      img[r][c] = int'(in_b[n].d);
      e.d = '0;
      for (int ch = 0; ch < 3; ch++) begin
        sum = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            if (r - dr >= 0 && c - dc >= 0) sum += (img[r-dr][c-dc] >> (8 * ch)) & 255;
        e.d[8*ch +: 8] = 8'(sum / 9);
      end
      e.u = in_b[n].u;
      e.l = in_b[n].l;
      exp_b.push_back(e);
      if (in_b[n].l) begin
        r++;
        c = 0;
      end else c++;
    end
  endtask

  task automatic make_frame(input int w, input int h, input bit rnd, input logic [23:0] cval,
                            output beat_t q[$]);
    beat_t b;
    q = {};
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        b.d = rnd ? 24'($urandom) : cval;
        b.u = (r == 0 && c == 0);
        b.l = (c == w - 1);
        q.push_back(b);
      end
  endtask

  task automatic drive(input beat_t q[$], input int vp);
    int guard;
    foreach (q[n]) begin
      @(posedge clk);
      #1;
      while ($urandom_range(99) >= vp) begin
        s_axis_video_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axis_video_tvalid = 1'b1;
      s_axis_video_tdata  = q[n].d;
      s_axis_video_tuser  = q[n].u;
      s_axis_video_tlast  = q[n].l;
      @(negedge clk);
      guard = 0;
      while (!s_axis_video_tready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (!s_axis_video_tready) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: beat %0d got tready=0 want 1", n);
        s_axis_video_tvalid = 1'b0;
        return;
      end
      in_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    s_axis_video_tvalid = 1'b0;
    s_axis_video_tuser  = 1'b0;
    s_axis_video_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int guard = 0;
    while (out_q.size() < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_queues();
    out_q = {};
    out_cyc = {};
    in_cyc = {};
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (m_axis_video_tvalid !== 1'b0) begin
      fails++; $display("FAIL reset_tvalid: got %b want 0", m_axis_video_tvalid);
    end
    tests++;
    if (m_axis_video_tdata !== 24'h0) begin
      fails++; $display("FAIL reset_tdata: got %h want 000000", m_axis_video_tdata);
    end
    tests++;
    if (m_axis_video_tuser !== 1'b0 || m_axis_video_tlast !== 1'b0) begin
      fails++; $display("FAIL reset_side: got %b%b want 00", m_axis_video_tuser, m_axis_video_tlast);
    end
    tests++;
    if (s_axis_video_tready !== 1'b0) begin
      fails++; $display("FAIL reset_tready: got %b want 0", s_axis_video_tready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    tests++;
    if (s_axis_video_tready !== 1'b1) begin
      fails++; $display("FAIL post_reset_tready: got %b want 1", s_axis_video_tready);
    end
  endtask

  task automatic test_constant();
    beat_t q[$];
    int bad = 0;
    make_frame(W, H, 0, 24'h909090, q);
    clear_queues();
    drive(q, 100);
    wait_outputs(W * H);
    tests++;
    if (out_q.size() != W * H) begin
      fails++; $display("FAIL const_count: got %0d want %0d", out_q.size(), W * H);
    end else begin
      tests++;
      if (out_q[0].d !== 24'h101010) begin
        fails++; $display("FAIL const_r0c0: got %h want 101010", out_q[0].d);
      end
      tests++;
      if (out_q[2].d !== 24'h303030) begin
        fails++; $display("FAIL const_r0c2: got %h want 303030", out_q[2].d);
      end
      tests++;
      if (out_q[W + 1].d !== 24'h404040) begin
        fails++; $display("FAIL const_r1c1: got %h want 404040", out_q[W + 1].d);
      end
      for (int r = 2; r < H; r++)
        for (int c = 2; c < W; c++)
          if (out_q[r * W + c].d !== 24'h909090) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL const_interior: got %0d wrong pixels want 0", bad);
      end
    end
  endtask

  task automatic test_white();
    beat_t q[$];
    int bad = 0;
    make_frame(W, H, 0, 24'hFFFFFF, q);
    clear_queues();
    drive(q, 100);
    wait_outputs(W * H);
    tests++;
    if (out_q.size() != W * H) begin
      fails++; $display("FAIL white_count: got %0d want %0d", out_q.size(), W * H);
    end else begin
      for (int r = 2; r < H; r++)
        for (int c = 2; c < W; c++)
          if (out_q[r * W + c].d !== 24'hFFFFFF) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL white_interior: got %0d wrong pixels want 0", bad);
      end
      tests++;
      if (out_q[0].d !== 24'h1C1C1C) begin
        fails++; $display("FAIL white_r0c0: got %h want 1c1c1c", out_q[0].d);
      end
    end
  endtask

  task automatic test_random_frame();
    beat_t ex[$];
    make_frame(W, H, 1, 24'h0, rand_frame);
    model(rand_frame, ex);
    clear_queues();
    drive(rand_frame, 100);
    wait_outputs(W * H);
    ref_out = out_q;
    tests++;
    if (out_q.size() != W * H) begin
      fails++; $display("FAIL rand_count: got %0d want %0d", out_q.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        tests++;
        if (out_q[i].d !== ex[i].d || out_q[i].u !== (i == 0) || out_q[i].l !== (i % W == W - 1)) begin
          fails++;
          $display("FAIL rand_beat %0d: got %h u%b l%b want %h u%b l%b", i, out_q[i].d,
                   out_q[i].u, out_q[i].l, ex[i].d, (i == 0), (i % W == W - 1));
        end
        tests++;
        if (out_cyc[i] - in_cyc[i] != 2) begin
          fails++; $display("FAIL rand_latency %0d: got %0d want 2", i, out_cyc[i] - in_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    rdy_pct = 60;
    stall_seen = 0;
    stall_bad = 0;
    clear_queues();
    drive(rand_frame, 70);
    wait_outputs(W * H);
    rdy_pct = 100;
    tests++;
    if (out_q.size() != W * H) begin
      fails++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        tests++;
        if (out_q[i] != ref_out[i]) begin
          fails++; $display("FAIL stall_beat %0d: got %h want %h", i, out_q[i].d, ref_out[i].d);
        end
      end
    end
    tests++;
    if (stall_bad != 0) begin
      fails++; $display("FAIL stall_hold: got %0d changes want 0", stall_bad);
    end
    tests++;
    if (stall_seen == 0) begin
      fails++; $display("FAIL stall_seen: got 0 stalled cycles want >0");
    end
  endtask

  task automatic test_reset_mid_line();
    beat_t q[$];
    beat_t part[$];
    beat_t ex[$];
    logic [23:0] want;
    make_frame(W, H, 1, 24'h0, q);
    part = q[0:2*W+6];
    clear_queues();
    drive(part, 100);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (m_axis_video_tvalid !== 1'b0 || m_axis_video_tdata !== 24'h0) begin
      fails++; $display("FAIL midreset_out: got v%b %h want v0 000000", m_axis_video_tvalid, m_axis_video_tdata);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    clear_queues();
    make_frame(W, 4, 1, 24'h0, q);
    model(q, ex);
    drive(q, 100);
    wait_outputs(W * 4);
    tests++;
    if (out_q.size() != W * 4) begin
      fails++; $display("FAIL midreset_count: got %0d want %0d", out_q.size(), W * 4);
    end else begin
      for (int ch = 0; ch < 3; ch++) want[8*ch +: 8] = 8'(((q[0].d >> (8 * ch)) & 24'hFF) / 9);
      tests++;
      if (out_q[0].d !== want) begin
        fails++; $display("FAIL midreset_first: got %h want %h", out_q[0].d, want);
      end
      for (int i = 0; i < W * 4; i++) begin
        tests++;
        if (out_q[i] != ex[i]) begin
          fails++; $display("FAIL midreset_beat %0d: got %h want %h", i, out_q[i].d, ex[i].d);
        end
      end
    end
  endtask

  task automatic test_mid_frame_tuser();
    beat_t q[$];
    beat_t nf[$];
    beat_t ex[$];
    logic [23:0] want;
    int base = 4 * W + 7;
    make_frame(W, H, 1, 24'h0, q);
    q = q[0:base-1];
    make_frame(W, 3, 1, 24'h0, nf);
    foreach (nf[i]) q.push_back(nf[i]);
    model(q, ex);
    clear_queues();
    drive(q, 100);
    wait_outputs(q.size());
    tests++;
    if (out_q.size() != q.size()) begin
      fails++; $display("FAIL restart_count: got %0d want %0d", out_q.size(), q.size());
    end else begin
      for (int ch = 0; ch < 3; ch++) want[8*ch +: 8] = 8'(((q[base].d >> (8 * ch)) & 24'hFF) / 9);
      tests++;
      if (out_q[base].d !== want || out_q[base].u !== 1'b1) begin
        fails++; $display("FAIL restart_first: got %h u%b want %h u1", out_q[base].d, out_q[base].u, want);
      end
      for (int ch = 0; ch < 3; ch++)
        want[8*ch +: 8] = 8'((((q[base].d >> (8 * ch)) & 24'hFF) + ((q[base+1].d >> (8 * ch)) & 24'hFF)) / 9);
      tests++;
      if (out_q[base + 1].d !== want) begin
        fails++; $display("FAIL restart_second: got %h want %h", out_q[base + 1].d, want);
      end
      foreach (ex[i]) begin
        tests++;
        if (out_q[i] != ex[i]) begin
          fails++; $display("FAIL restart_beat %0d: got %h want %h", i, out_q[i].d, ex[i].d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_white();
    test_random_frame();
    test_back_pressure();
    test_reset_mid_line();
    test_mid_frame_tuser();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
